// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decoder feeding a main+skid output buffer.
// Define DECODE_ILLEGAL_TRAP_EN to flag illegal encodings on illegal_o instead of emitting NOPs.
module decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NB_UNIT      = 6,
  parameter int unsigned NB_OPERATION = 6,
  parameter int unsigned NB_REGS      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XLEN-1:0]         in_pc_i,
  input  logic [31:0]             in_instr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         pc_o,
  output logic [NB_UNIT-1:0]      unit_o,
  output logic [NB_OPERATION-1:0] op_o,
  output logic                    inv_o,
  output logic [1:0]              size_o,
  output logic [NB_REGS-1:0]      rs1_o,
  output logic [NB_REGS-1:0]      rs2_o,
  output logic [NB_REGS-1:0]      rd_o,
  output logic                    rd_we_o,
  output logic [XLEN-1:0]         imm_o,
  output logic                    use_imm_o,
  output logic                    use_pc_o,
  output logic                    illegal_o
);

  localparam int unsigned UAlu = 0, USft = 1, UBu = 2, ULsu = 3;
  localparam int unsigned OAdd = 0, OAnd = 1, OOr = 2, OXor = 3, OSlt = 4;
  localparam int unsigned OSll = 0, OSrl = 1, OSra = 2;
  localparam int unsigned OBeq = 0, OBne = 1, OBlt = 2, OBge = 3, OJal = 4, OJalr = 5;
  localparam int unsigned OSt = 0, OLd = 1;

  localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpBranch = 7'b1100011, OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011, OpImm = 7'b0010011, OpReg = 7'b0110011;
  localparam logic [6:0] OpFence = 7'b0001111;

  localparam logic [1:0] StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2;

  localparam int unsigned PW = 2 * XLEN + NB_UNIT + NB_OPERATION + 3 * NB_REGS + 7;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        f7_ok;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign opcode = in_instr_i[6:0];
  assign f3     = in_instr_i[14:12];
  assign f7     = in_instr_i[31:25];
  assign f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);
  assign imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
  assign imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
  assign imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                   in_instr_i[11:8], 1'b0};
  assign imm_u  = {in_instr_i[31:12], 12'b0};
  assign imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                   in_instr_i[30:21], 1'b0};

  logic [NB_UNIT-1:0]      d_unit;
  logic [NB_OPERATION-1:0] d_op;
  logic [NB_REGS-1:0]      d_rs1, d_rs2, d_rd;
  logic [1:0]              d_size;
  logic                    d_inv, d_we, d_use_imm, d_use_pc, d_ill, d_nop;

  always_comb begin
    d_unit = '0; d_op = '0; d_inv = 1'b0; d_size = 2'd0;
    d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_we = 1'b0; imm32 = '0;
    d_use_imm = 1'b0; d_use_pc = 1'b0; d_ill = 1'b0; d_nop = 1'b0;
    case (opcode)
      OpReg, OpImm: begin
        d_rs1 = NB_REGS'(in_instr_i[19:15]);
        d_rd  = NB_REGS'(in_instr_i[11:7]);
        d_we  = 1'b1;
        case (f3)
          3'b000: begin d_unit[UAlu] = 1'b1; d_op[OAdd] = 1'b1; end
          3'b001: begin d_unit[USft] = 1'b1; d_op[OSll] = 1'b1; end
          3'b010: begin d_unit[UAlu] = 1'b1; d_op[OSlt] = 1'b1; end
          3'b011: begin d_unit[UAlu] = 1'b1; d_op[OSlt] = 1'b1; d_inv = 1'b1; end
          3'b100: begin d_unit[UAlu] = 1'b1; d_op[OXor] = 1'b1; end
          3'b101: begin
            d_unit[USft] = 1'b1;
            if (f7[5]) d_op[OSra] = 1'b1;
            else       d_op[OSrl] = 1'b1;
          end
          3'b110:  begin d_unit[UAlu] = 1'b1; d_op[OOr] = 1'b1; end
          default: begin d_unit[UAlu] = 1'b1; d_op[OAnd] = 1'b1; end
        endcase
        if (opcode == OpReg) begin
          d_rs2 = NB_REGS'(in_instr_i[24:20]);
          d_inv = d_inv | ((f3 == 3'b000) & f7[5]);
          // funct7 = 0100000 only exists for SUB and SRA
          d_ill = !f7_ok || (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
        end else begin
          d_use_imm = 1'b1;
          if ((f3 == 3'b001) || (f3 == 3'b101)) begin
            imm32 = {27'b0, in_instr_i[24:20]};
            d_ill = !f7_ok;
          end else begin
            imm32 = imm_i;
          end
        end
      end
      OpLui, OpAuipc: begin
        d_unit[UAlu] = 1'b1; d_op[OAdd] = 1'b1;
        d_rd = NB_REGS'(in_instr_i[11:7]); d_we = 1'b1;
        imm32 = imm_u; d_use_imm = 1'b1;
        d_use_pc = (opcode == OpAuipc);
      end
      OpLoad: begin
        d_unit[ULsu] = 1'b1; d_op[OLd] = 1'b1;
        d_rs1 = NB_REGS'(in_instr_i[19:15]);
        d_rd = NB_REGS'(in_instr_i[11:7]); d_we = 1'b1;
        imm32 = imm_i; d_use_imm = 1'b1;
        d_size = f3[1:0]; d_inv = f3[2];
        d_ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OpStore: begin
        d_unit[ULsu] = 1'b1; d_op[OSt] = 1'b1;
        d_rs1 = NB_REGS'(in_instr_i[19:15]);
        d_rs2 = NB_REGS'(in_instr_i[24:20]);
        imm32 = imm_s; d_use_imm = 1'b1;
        d_size = f3[1:0];
        d_ill = (f3 > 3'b010);
      end
      OpBranch: begin
        d_unit[UBu] = 1'b1;
        d_rs1 = NB_REGS'(in_instr_i[19:15]);
        d_rs2 = NB_REGS'(in_instr_i[24:20]);
        imm32 = imm_b; d_inv = f3[1];
        case (f3)
          3'b000:         d_op[OBeq] = 1'b1;
          3'b001:         d_op[OBne] = 1'b1;
          3'b100, 3'b110: d_op[OBlt] = 1'b1;
          3'b101, 3'b111: d_op[OBge] = 1'b1;
          default:        d_ill = 1'b1;
        endcase
      end
      OpJal: begin
        d_unit[UBu] = 1'b1; d_op[OJal] = 1'b1;
        d_rd = NB_REGS'(in_instr_i[11:7]); d_we = 1'b1;
        imm32 = imm_j;
      end
      OpJalr: begin
        d_unit[UBu] = 1'b1; d_op[OJalr] = 1'b1;
        d_rs1 = NB_REGS'(in_instr_i[19:15]);
        d_rd = NB_REGS'(in_instr_i[11:7]); d_we = 1'b1;
        imm32 = imm_i; d_use_imm = 1'b1;
        d_ill = (f3 != 3'b000);
      end
      OpFence: d_nop = 1'b1;
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      d_unit = '0; d_op = '0; d_we = 1'b0;
`else
      d_nop = 1'b1; d_ill = 1'b0;
`endif
    end
    if (d_nop) begin
      d_unit = '0; d_op = '0; d_unit[UAlu] = 1'b1; d_op[OAdd] = 1'b1;
      d_we = 1'b0; d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_inv = 1'b0;
      d_size = 2'd0; d_use_imm = 1'b0; d_use_pc = 1'b0;
    end
    if (d_rd == '0) d_we = 1'b0;
  end

  logic [PW-1:0] dec, main_q, main_d, skid_q, skid_d;
  logic [1:0]    state_q, state_d;
  logic          in_ready_q, accept, consume;

  assign dec = {in_pc_i, d_unit, d_op, d_inv, d_size, d_rs1, d_rs2, d_rd, d_we,
                {{(XLEN-31){imm32[31]}}, imm32[30:0]}, d_use_imm, d_use_pc, d_ill};
  assign {pc_o, unit_o, op_o, inv_o, size_o, rs1_o, rs2_o, rd_o, rd_we_o,
          imm_o, use_imm_o, use_pc_o, illegal_o} = main_q;

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != StEmpty);
  assign accept      = in_valid_i & in_ready_q;
  assign consume     = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) begin state_d = StOne; main_d = dec; end
        StOne: begin
          if (accept && consume) main_d = dec;
          else if (accept) begin state_d = StTwo; skid_d = dec; end
          else if (consume) state_d = StEmpty;
        end
        StTwo:   if (consume) begin state_d = StOne; main_d = skid_q; end
        default: state_d = StEmpty;
      endcase
    end
  end

  // in_ready is registered: it looks ahead at the next buffer state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; follows DECODE_ILLEGAL_TRAP_EN when defined.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] in_pc_i, in_instr_i, pc_o, imm_o;
  logic [5:0]  unit_o, op_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [1:0]  size_o;
  logic        inv_o, rd_we_o, use_imm_o, use_pc_o, illegal_o;

  int n_pass = 0;
  int n_total = 0;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_pc_i    (in_pc_i),
    .in_instr_i (in_instr_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .pc_o       (pc_o),
    .unit_o     (unit_o),
    .op_o       (op_o),
    .inv_o      (inv_o),
    .size_o     (size_o),
    .rs1_o      (rs1_o),
    .rs2_o      (rs2_o),
    .rd_o       (rd_o),
    .rd_we_o    (rd_we_o),
    .imm_o      (imm_o),
    .use_imm_o  (use_imm_o),
    .use_pc_o   (use_pc_o),
    .illegal_o  (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    in_valid_i = 1'b1;
    in_pc_i    = pc;
    in_instr_i = instr;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_pc_i = '0; in_instr_i = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_fields", {unit_o, op_o, rs1_o, rs2_o, rd_o, inv_o, rd_we_o, illegal_o}, 32'd0);

    // sub x2,x1,x2
    out_ready_i = 1'b1;
    push(32'h100, 32'h40208133);
    step();
    in_valid_i = 1'b0;
    chk("sub_valid", {31'b0, out_valid_o}, 32'd1);
    chk("sub_unit", {26'b0, unit_o}, 32'h01);
    chk("sub_op", {26'b0, op_o}, 32'h01);
    chk("sub_inv", {31'b0, inv_o}, 32'd1);
    chk("sub_regs", {17'b0, rs1_o, rs2_o, rd_o}, {17'b0, 5'd1, 5'd2, 5'd2});
    chk("sub_we", {31'b0, rd_we_o}, 32'd1);
    chk("sub_pc", pc_o, 32'h100);
    step();
    chk("sub_drained", {31'b0, out_valid_o}, 32'd0);

    // lw x5,-4(x6) then beq x1,x0,+8 with issue stalled
    out_ready_i = 1'b0;
    push(32'h200, 32'hFFC32283);
    step();
    chk("b2b_ready_after_1", {31'b0, in_ready_o}, 32'd1);
    push(32'h204, 32'h00008463);
    step();
    in_valid_i = 1'b0;
    chk("b2b_ready_after_2", {31'b0, in_ready_o}, 32'd0);
    step();
    chk("lw_pc_held", pc_o, 32'h200);
    chk("lw_unit", {26'b0, unit_o}, 32'h08);
    chk("lw_op", {26'b0, op_o}, 32'h02);
    chk("lw_imm", imm_o, 32'hFFFFFFFC);
    chk("lw_size", {30'b0, size_o}, 32'd2);
    chk("lw_regs", {17'b0, rs1_o, rs2_o, rd_o}, {17'b0, 5'd6, 5'd0, 5'd5});
    chk("lw_we_imm", {30'b0, rd_we_o, use_imm_o}, 32'd3);
    out_ready_i = 1'b1;
    step();
    chk("beq_valid", {31'b0, out_valid_o}, 32'd1);
    chk("beq_pc", pc_o, 32'h204);
    chk("beq_unit", {26'b0, unit_o}, 32'h04);
    chk("beq_op", {26'b0, op_o}, 32'h01);
    chk("beq_imm", imm_o, 32'd8);
    chk("beq_we", {31'b0, rd_we_o}, 32'd0);
    chk("beq_ready", {31'b0, in_ready_o}, 32'd1);
    step();
    chk("beq_drained", {31'b0, out_valid_o}, 32'd0);

    // addi x0,x0,1 ; lui x3,0x12345 ; auipc x4,1 at full throughput
    push(32'h300, 32'h00100013);
    step();
    chk("addi_we", {31'b0, rd_we_o}, 32'd0);
    chk("addi_imm", imm_o, 32'd1);
    push(32'h304, 32'h123451B7);
    step();
    chk("lui_pc", pc_o, 32'h304);
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_rs1", {27'b0, rs1_o}, 32'd0);
    chk("lui_flags", {29'b0, use_imm_o, use_pc_o, rd_we_o}, 32'b101);
    push(32'h308, 32'h00001217);
    step();
    in_valid_i = 1'b0;
    chk("auipc_imm", imm_o, 32'h1000);
    chk("auipc_flags", {27'b0, rd_o, use_pc_o}, {27'b0, 5'd4, 1'b1});
    step();

    // all-ones word is never a legal RV32I encoding
    push(32'h400, 32'hFFFFFFFF);
    step();
    in_valid_i = 1'b0;
    chk("ill_pc", pc_o, 32'h400);
    chk("ill_we", {31'b0, rd_we_o}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", {31'b0, illegal_o}, 32'd1);
    chk("ill_unit", {26'b0, unit_o}, 32'd0);
`else
    chk("ill_flag", {31'b0, illegal_o}, 32'd0);
    chk("nop_unit_op", {20'b0, unit_o, op_o}, {20'b0, 6'h01, 6'h01});
`endif
    step();

    // flush from ONE with a same-cycle input
    out_ready_i = 1'b0;
    push(32'h500, 32'h00100093);
    step();
    push(32'h504, 32'h123451B7);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush1_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush1_ready", {31'b0, in_ready_o}, 32'd1);

    // flush from TWO with a pending input
    push(32'h600, 32'h00100093);
    step();
    push(32'h604, 32'h123451B7);
    step();
    chk("flush2_full", {31'b0, in_ready_o}, 32'd0);
    push(32'h608, 32'h40208133);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush2_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush2_ready", {31'b0, in_ready_o}, 32'd1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_stale", {31'b0, out_valid_o}, 32'd0);
    end
    push(32'h700, 32'h40208133);
    step();
    in_valid_i = 1'b0;
    chk("post_flush_pc", pc_o, 32'h700);
    chk("post_flush_valid", {31'b0, out_valid_o}, 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
